// File: rtl/store_merge_unit.sv
// rtl/store_merge_unit.sv - read-modify-write store narrowing for a word-only data memory
//
// Purpose: accepts an SB/SH/SW store and narrows the register value to the
// addressed big-endian byte or halfword lane. That lane is merged into the
// existing memory word by a read followed by a write, because the memory has
// no byte enables. Word stores skip the read. Misaligned or reserved-size
// requests are rejected without touching memory.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-low reset
//   req_valid/ready  store request handshake; ready only while idle
//   req_addr         byte address
//   req_size         00 byte, 01 halfword, 10 word, 11 reserved
//   req_data         register value (low byte/halfword used for narrow stores)
//   req_done         one-cycle pulse when the store has committed
//   req_err          one-cycle pulse on a misaligned or reserved-size request
//   mem_addr         word-aligned memory address
//   mem_rd / mem_wr  read / write strobes, held until mem_ack
//   mem_wdata        full merged word
//   mem_rdata        read data, valid with mem_ack during a read
//   mem_ack          memory completion, one or more cycles after the strobe
module store_merge_unit #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [1:0]           req_size,
  input  logic [DATA_SIZE-1:0] req_data,
  output logic                 req_done,
  output logic                 req_err,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack
);

  localparam int SHW = $clog2(DATA_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_SIZE-1:0] addr_q;
  logic [DATA_SIZE-1:0] wdata_q;
  logic [1:0]           off_q;
  logic                 half_q;
  logic [15:0]          data_q;

  logic                 accept;
  logic                 bad_req;
  logic [SHW-1:0]       shift;
  logic [DATA_SIZE-1:0] lane_mask;
  logic [DATA_SIZE-1:0] lane_data;
  logic [DATA_SIZE-1:0] merged;

  assign accept = req_valid && (state_q == S_IDLE);

  always_comb begin
    bad_req = 1'b0;
    case (req_size)
      2'b01:   bad_req = req_addr[0];
      2'b10:   bad_req = (req_addr[1:0] != 2'b00);
      2'b11:   bad_req = 1'b1;
      default: bad_req = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    req_done  = 1'b0;
    req_err   = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (bad_req)                state_d = S_ERR;
          else if (req_size == 2'b10) state_d = S_WRITE;
          else                        state_d = S_READ;
        end
      end
      S_READ: begin
        mem_rd = 1'b1;
        if (mem_ack) state_d = S_WRITE;
      end
      S_WRITE: begin
        mem_wr = 1'b1;
        if (mem_ack) state_d = S_DONE;
      end
      S_DONE: begin
        req_done = 1'b1;
        state_d  = S_IDLE;
      end
      S_ERR: begin
        req_err = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Big-endian lanes: byte offset 0 is the most significant byte, halfword
  // offset 0 is the upper half.
  always_comb begin
    shift = '0;
    if (half_q) begin
      shift = off_q[1] ? SHW'(0) : SHW'(16);
    end else begin
      case (off_q)
        2'd0:    shift = SHW'(24);
        2'd1:    shift = SHW'(16);
        2'd2:    shift = SHW'(8);
        default: shift = SHW'(0);
      endcase
    end
    lane_mask = (half_q ? DATA_SIZE'(16'hFFFF) : DATA_SIZE'(8'hFF)) << shift;
    lane_data = (half_q ? DATA_SIZE'(data_q) : DATA_SIZE'(data_q[7:0])) << shift;
    merged    = (mem_rdata & ~lane_mask) | (lane_data & lane_mask);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      half_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      if (accept && !bad_req) begin
        addr_q <= {req_addr[ADDR_SIZE-1:2], 2'b00};
        off_q  <= req_addr[1:0];
        half_q <= req_size[0];
        data_q <= req_data[15:0];
        if (req_size == 2'b10) wdata_q <= req_data;
      end
      if ((state_q == S_READ) && mem_ack) wdata_q <= merged;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// tb/tb_store_merge_unit.sv - directed table-driven bench for store_merge_unit
module tb_store_merge_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_data = '0;
  logic        req_done;
  logic        req_err;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  store_merge_unit #(.DATA_SIZE(32), .ADDR_SIZE(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_data(req_data),
    .req_done(req_done), .req_err(req_err),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: one word, delay-configurable ack, protocol monitor.
  logic [31:0] preload = 32'h11223344;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          rd_cnt = 0, wr_cnt = 0, rd_cyc = 0, wr_cyc = 0;
  int          done_cnt = 0, both_cnt = 0, stab_cnt = 0;
  logic [31:0] last_wr_data = '0, last_wr_addr = '0, last_rd_addr = '0;
  logic        prev_pend = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;

  always @(negedge clk) begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0BAD0BAD;
    if (mem_rd && mem_wr) both_cnt++;
    if (req_done) done_cnt++;
    if (mem_rd) rd_cyc++;
    if (mem_wr) wr_cyc++;
    if (rst && prev_pend) begin
      if (mem_rd !== prev_rd || mem_wr !== prev_wr || mem_addr !== prev_addr ||
          (mem_wr && mem_wdata !== prev_wdata))
        stab_cnt++;
    end
    if (rst && (mem_rd || mem_wr)) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        if (mem_rd) begin
          mem_rdata    = preload;
          rd_cnt++;
          last_rd_addr = mem_addr;
        end else begin
          last_wr_data = mem_wdata;
          last_wr_addr = mem_addr;
          wr_cnt++;
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    prev_pend  = rst && (mem_rd || mem_wr) && !mem_ack;
    prev_rd    = mem_rd;
    prev_wr    = mem_wr;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
  end

  task automatic do_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d,
                          output int lat, output logic got_done, output logic got_err);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_size  = s;
    req_data  = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!(req_done || req_err) && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    got_done = req_done;
    got_err  = req_err;
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] data;
    logic        exp_err;
    int          exp_rd;
    logic [31:0] exp_word;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int          lat;
    logic        gd, ge;
    int          rd0, wr0, rdc0, wrc0, done0;

    vecs[0] = '{"sb_102",   32'h102, 2'b00, 32'hFFFFFFAB, 1'b0, 1, 32'h1122AB44, 3};
    vecs[1] = '{"sh_102",   32'h102, 2'b01, 32'h1234BEEF, 1'b0, 1, 32'h1122BEEF, 3};
    vecs[2] = '{"sh_100",   32'h100, 2'b01, 32'h0000CAFE, 1'b0, 1, 32'hCAFE3344, 3};
    vecs[3] = '{"sw_100",   32'h100, 2'b10, 32'hDEADBEEF, 1'b0, 0, 32'hDEADBEEF, 2};
    vecs[4] = '{"sh_101",   32'h101, 2'b01, 32'h0000AAAA, 1'b1, 0, 32'h0,        1};
    vecs[5] = '{"sw_102",   32'h102, 2'b10, 32'h12345678, 1'b1, 0, 32'h0,        1};
    vecs[6] = '{"sz11_100", 32'h100, 2'b11, 32'h12345678, 1'b1, 0, 32'h0,        1};
    vecs[7] = '{"sb_100",   32'h100, 2'b00, 32'h000000AB, 1'b0, 1, 32'hAB223344, 3};
    vecs[8] = '{"sb_101",   32'h101, 2'b00, 32'h00000077, 1'b0, 1, 32'h11773344, 3};
    vecs[9] = '{"sb_103",   32'h103, 2'b00, 32'h0000005A, 1'b0, 1, 32'h1122335A, 3};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rd",    32'(mem_rd),    32'd0);
    check("rst_wr",    32'(mem_wr),    32'd0);
    check("rst_done",  32'(req_done),  32'd0);
    check("rst_err",   32'(req_err),   32'd0);
    check("rst_addr",  mem_addr,       32'h0);
    check("rst_wdata", mem_wdata,      32'h0);
    rst = 1'b1;

    // Table: single-cycle ack
    ack_delay = 0;
    for (int i = 0; i < 10; i++) begin
      rd0 = rd_cnt; wr0 = wr_cnt; rdc0 = rd_cyc; wrc0 = wr_cyc;
      do_store(vecs[i].addr, vecs[i].size, vecs[i].data, lat, gd, ge);
      check({vecs[i].name, "_err"},  32'(ge),  32'(vecs[i].exp_err));
      check({vecs[i].name, "_done"}, 32'(gd),  32'(!vecs[i].exp_err));
      check({vecs[i].name, "_lat"},  32'(lat), 32'(vecs[i].exp_lat));
      check({vecs[i].name, "_rds"},  32'(rd_cnt - rd0), 32'(vecs[i].exp_rd));
      if (vecs[i].exp_err) begin
        check({vecs[i].name, "_strobes"}, 32'((rd_cyc - rdc0) + (wr_cyc - wrc0)), 32'd0);
      end else begin
        check({vecs[i].name, "_wrs"},   32'(wr_cnt - wr0), 32'd1);
        check({vecs[i].name, "_word"},  last_wr_data, vecs[i].exp_word);
        check({vecs[i].name, "_waddr"}, last_wr_addr, 32'h100);
        if (vecs[i].exp_rd != 0) check({vecs[i].name, "_raddr"}, last_rd_addr, 32'h100);
      end
      @(negedge clk);
      check({vecs[i].name, "_ready_back"}, 32'(req_ready), 32'd1);
      check({vecs[i].name, "_pulse_end"},  32'(req_done | req_err), 32'd0);
    end

    // Slow memory; requests during the busy period must be ignored
    ack_delay = 3;
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h103; req_size = 2'b00; req_data = 32'h000000CD;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("busy_ready", 32'(req_ready), 32'd0);
      req_valid = 1'b1; req_addr = 32'h200; req_size = 2'b10; req_data = 32'h55555555;
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!req_done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("slow_done",  32'(req_done), 32'd1);
    check("slow_word",  last_wr_data, 32'h112233CD);
    check("slow_waddr", last_wr_addr, 32'h100);
    check("slow_raddr", last_rd_addr, 32'h100);
    repeat (6) @(negedge clk);
    check("slow_rds", 32'(rd_cnt - rd0), 32'd1);
    check("slow_wrs", 32'(wr_cnt - wr0), 32'd1);

    // Reset during WRITE abandons the store
    ack_delay = 6;
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h102; req_size = 2'b00; req_data = 32'h00000099;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!mem_wr && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("rstw_in_write", 32'(mem_wr), 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rstw_wr",    32'(mem_wr),    32'd0);
    check("rstw_rd",    32'(mem_rd),    32'd0);
    check("rstw_ready", 32'(req_ready), 32'd1);
    check("rstw_addr",  mem_addr,       32'h0);
    check("rstw_wdata", mem_wdata,      32'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    wrc0 = wr_cyc; done0 = done_cnt;
    repeat (10) @(negedge clk);
    check("rstw_no_wr_strobe", 32'(wr_cyc - wrc0),    32'd0);
    check("rstw_no_done",      32'(done_cnt - done0), 32'd0);
    check("rstw_wr_acks",      32'(wr_cnt - wr0),     32'd0);
    check("rstw_rd_acks",      32'(rd_cnt - rd0),     32'd1);

    // Protocol invariants over the whole run
    check("never_rd_and_wr", 32'(both_cnt), 32'd0);
    check("strobe_stable",   32'(stab_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
